// File: rtl/cosine_similarity_pkg.sv
// Shared types, FP32 constants and classification helpers for the cosine
// similarity finalize stage and the FP IP models it drives.
package cosine_similarity_pkg;

  localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_INF  = 32'h7F80_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_SQRT,
    S_DIV,
    S_OUT
  } cosine_finalize_state_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  expo;
    logic [22:0] man;
  } fp32_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Exponent all-ones covers both NaN and infinity.
  function automatic logic is_nan_inf(input logic [31:0] x);
    return x[30:23] == 8'hFF;
  endfunction

  function automatic logic is_zero(input logic [31:0] x);
    return x[30:0] == 31'd0;
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  // Zero exponent: true zero or subnormal, both treated as zero by the IPs.
  function automatic logic is_flush_zero(input logic [31:0] x);
    return x[30:23] == 8'h00;
  endfunction

  // Rounding can push |cos| just past 1.0; pull it back while keeping the sign.
  // A NaN coming out of the sqrt/div chain is passed through untouched.
  function automatic logic [31:0] clamp_unit(input logic [31:0] q);
    if (is_nan(q)) return q;
    if (q[30:0] > FP32_ONE[30:0]) return {q[31], FP32_ONE[30:0]};
    return q;
  endfunction

endpackage

// File: rtl/cosine_similarity_finalize_if.sv
// Request/response bundle between the accumulator side and the finalize stage.
interface cosine_similarity_finalize_if #(
  parameter int HV_DATA_WIDTH = 32
);
  logic                     start;
  logic [HV_DATA_WIDTH-1:0] AA_in;
  logic [HV_DATA_WIDTH-1:0] BB_in;
  logic [HV_DATA_WIDTH-1:0] AB_in;
  logic                     ready;
  logic [HV_DATA_WIDTH-1:0] result;
  logic                     result_valid;
  logic                     zero_norm;
  logic                     nan_flag;

  modport master (
    output start, AA_in, BB_in, AB_in,
    input  ready, result, result_valid, zero_norm, nan_flag
  );

  modport slave (
    input  start, AA_in, BB_in, AB_in,
    output ready, result, result_valid, zero_norm, nan_flag
  );
endinterface

// File: rtl/fp_div.sv
// FP32 divider model (a / b): normals only, subnormals flushed, round toward
// zero. Same latency convention as fp_mult.
module fp_div
  import cosine_similarity_pkg::*;
#(
  parameter int LAT = 10
) (
  input  logic        clk,
  input  logic        areset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q
);
  fp32_t             fa, fb;
  logic              sgn;
  logic [24:0]       quo;
  logic signed [9:0] exp_diff;
  logic [31:0]       res;

  assign fa = a;
  assign fb = b;

  always_comb begin
    sgn      = fa.sign ^ fb.sign;
    // Mantissa ratio lies in (0.5, 2), so quo lands in [2^23, 2^25).
    quo      = 25'({1'b1, fa.man, 24'd0} / 48'({1'b1, fb.man}));
    exp_diff = 10'(fa.expo) - 10'(fb.expo) + 10'd126 + 10'(quo[24]);
    if (is_nan(a) || is_nan(b) || (is_inf(a) && is_inf(b)) ||
        (is_flush_zero(a) && is_flush_zero(b)))
      res = FP32_QNAN;
    else if (is_inf(a) || is_flush_zero(b))
      res = {sgn, FP32_INF[30:0]};
    else if (is_inf(b) || is_flush_zero(a))
      res = {sgn, 31'd0};
    else if (exp_diff >= 10'sd255)
      res = {sgn, FP32_INF[30:0]};
    else if (exp_diff <= 10'sd0)
      res = {sgn, 31'd0};
    else
      res = {sgn, exp_diff[7:0], quo[24] ? quo[23:1] : quo[22:0]};
  end

  generate
    if (LAT < 2) begin : g_comb
      assign q = res;
    end else begin : g_pipe
      logic [31:0] pipe [LAT-1];
      always_ff @(posedge clk) begin
        if (areset) begin
          for (int i = 0; i < LAT - 1; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= res;
          for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign q = pipe[LAT-2];
    end
  endgenerate
endmodule

// File: rtl/fp_mult.sv
// FP32 multiplier model: normals only, subnormals flushed, round toward zero.
// q reflects operands held LAT cycles, counting the consumer's capture edge.
module fp_mult
  import cosine_similarity_pkg::*;
#(
  parameter int LAT = 3
) (
  input  logic        clk,
  input  logic        areset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q
);
  fp32_t              fa, fb;
  logic               sgn;
  logic [24:0]        prod_top;
  logic signed [9:0]  exp_sum;
  logic [31:0]        res;

  assign fa = a;
  assign fb = b;

  always_comb begin
    sgn      = fa.sign ^ fb.sign;
    prod_top = 25'((48'({1'b1, fa.man}) * 48'({1'b1, fb.man})) >> 23);
    exp_sum  = 10'(fa.expo) + 10'(fb.expo) + 10'(prod_top[24]) - 10'd127;
    if (is_nan(a) || is_nan(b) ||
        (is_inf(a) && is_flush_zero(b)) || (is_inf(b) && is_flush_zero(a)))
      res = FP32_QNAN;
    else if (is_inf(a) || is_inf(b))
      res = {sgn, FP32_INF[30:0]};
    else if (is_flush_zero(a) || is_flush_zero(b))
      res = {sgn, 31'd0};
    else if (exp_sum >= 10'sd255)
      res = {sgn, FP32_INF[30:0]};
    else if (exp_sum <= 10'sd0)
      res = {sgn, 31'd0};
    else
      res = {sgn, exp_sum[7:0], prod_top[24] ? prod_top[23:1] : prod_top[22:0]};
  end

  generate
    if (LAT < 2) begin : g_comb
      assign q = res;
    end else begin : g_pipe
      logic [31:0] pipe [LAT-1];
      always_ff @(posedge clk) begin
        // NOTE: the delay line is reset so q never carries X or a stale
        // result out of a previous run.
        if (areset) begin
          for (int i = 0; i < LAT - 1; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= res;
          for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign q = pipe[LAT-2];
    end
  endgenerate
endmodule

// File: rtl/fp_sqrt.sv
// FP32 square-root model: normals only, negative input gives quiet NaN,
// round toward zero. Same latency convention as fp_mult.
module fp_sqrt
  import cosine_similarity_pkg::*;
#(
  parameter int LAT = 8
) (
  input  logic        clk,
  input  logic        areset,
  input  logic [31:0] a,
  output logic [31:0] q
);
  fp32_t       fa;
  logic [47:0] rad;
  logic [23:0] root, trial;
  logic [7:0]  res_exp;
  logic [31:0] res;

  assign fa = a;

  always_comb begin
    // An even unbiased exponent (odd biased) keeps the mantissa as is;
    // otherwise one extra bit of shift folds the odd power of two in.
    rad     = fa.expo[0] ? {1'b0, 1'b1, fa.man, 23'd0} : {1'b1, fa.man, 24'd0};
    res_exp = 8'((9'(fa.expo) + (fa.expo[0] ? 9'd127 : 9'd126)) >> 1);
    root    = '0;
    trial   = '0;
    for (int i = 23; i >= 0; i--) begin
      trial = root | (24'd1 << i);
      if (({24'd0, trial} * {24'd0, trial}) <= rad) root = trial;
    end
    if (is_nan(a))
      res = FP32_QNAN;
    else if (is_flush_zero(a))
      res = {fa.sign, 31'd0};
    else if (fa.sign)
      res = FP32_QNAN;
    else if (is_inf(a))
      res = FP32_INF;
    else
      res = {1'b0, res_exp, root[22:0]};
  end

  generate
    if (LAT < 2) begin : g_comb
      assign q = res;
    end else begin : g_pipe
      logic [31:0] pipe [LAT-1];
      always_ff @(posedge clk) begin
        if (areset) begin
          for (int i = 0; i < LAT - 1; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= res;
          for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign q = pipe[LAT-2];
    end
  endgenerate
endmodule

// File: rtl/cosine_similarity_finalize.sv
// Computes cos = AB / sqrt(AA*BB) from the accumulator sums, sharing one
// multiplier, one sqrt and one divider under a latency-counting FSM.
module cosine_similarity_finalize
  import cosine_similarity_pkg::*;
#(
  parameter int HV_DATA_WIDTH = 32,
  parameter int MUL_LAT       = 3,
  parameter int SQRT_LAT      = 8,
  parameter int DIV_LAT       = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  cosine_similarity_finalize_if.slave bus
);
  localparam int CNT_W = $clog2(max3(MUL_LAT, SQRT_LAT, DIV_LAT) + 1);

  typedef logic [HV_DATA_WIDTH-1:0] word_t;

  cosine_finalize_state_t state, next_state;
  logic [CNT_W-1:0]       cnt, cnt_load;
  logic                   cnt_done, accept, in_nan, in_zero;
  logic                   ready, result_valid;
  logic                   zero_norm_q, nan_flag_q;
  word_t                  aa_q, bb_q, ab_q, p_q, s_q, result_q;
  word_t                  mult_a, mult_b, mult_q;
  word_t                  sqrt_a, sqrt_q;
  word_t                  div_a, div_b, div_q;

  assign cnt_done = (cnt == '0);
  assign in_nan   = is_nan_inf(bus.AA_in) | is_nan_inf(bus.BB_in) | is_nan_inf(bus.AB_in);
  assign in_zero  = is_zero(bus.AA_in) | is_zero(bus.BB_in);
  assign accept   = bus.start & ready;

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    // NOTE: defaulting every output first keeps this block free of latches
    // on paths that do not assign it.
    next_state = state;
    unique case (state)
      S_IDLE:  if (accept) next_state = (in_nan || in_zero) ? S_OUT : S_MUL;
      S_MUL:   if (cnt_done) next_state = S_SQRT;
      S_SQRT:  if (cnt_done) next_state = S_DIV;
      S_DIV:   if (cnt_done) next_state = S_OUT;
      S_OUT:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Each IP sees its operands only while its own state is active.
  always_comb begin
    ready        = 1'b0;
    result_valid = 1'b0;
    mult_a       = '0;
    mult_b       = '0;
    sqrt_a       = '0;
    div_a        = '0;
    div_b        = '0;
    unique case (state)
      S_IDLE:  ready = 1'b1;
      S_MUL:   begin mult_a = aa_q; mult_b = bb_q; end
      S_SQRT:  sqrt_a = p_q;
      S_DIV:   begin div_a = ab_q; div_b = s_q; end
      S_OUT:   result_valid = 1'b1;
      default: ;
    endcase
  end

  // Counter is loaded with LAT-1 on entry, so the stage ends after LAT cycles.
  always_comb begin
    cnt_load = '0;
    unique case (next_state)
      S_MUL:   cnt_load = CNT_W'(MUL_LAT - 1);
      S_SQRT:  cnt_load = CNT_W'(SQRT_LAT - 1);
      S_DIV:   cnt_load = CNT_W'(DIV_LAT - 1);
      default: cnt_load = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                    cnt <= '0;
    else if (next_state != state) cnt <= cnt_load;
    else if (!cnt_done)           cnt <= cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aa_q        <= '0;
      bb_q        <= '0;
      ab_q        <= '0;
      p_q         <= '0;
      s_q         <= '0;
      result_q    <= FP32_ZERO;
      zero_norm_q <= 1'b0;
      nan_flag_q  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (accept) begin
          aa_q <= bus.AA_in;
          bb_q <= bus.BB_in;
          ab_q <= bus.AB_in;
          if (in_nan) begin
            result_q    <= FP32_QNAN;
            nan_flag_q  <= 1'b1;
            zero_norm_q <= 1'b0;
          end else if (in_zero) begin
            result_q    <= FP32_ZERO;
            nan_flag_q  <= 1'b0;
            zero_norm_q <= 1'b1;
          end
        end
        S_MUL:  if (cnt_done) p_q <= mult_q;
        S_SQRT: if (cnt_done) s_q <= sqrt_q;
        // The quotient is clamped as it is registered, so result is already
        // final during the S_OUT cycle that carries result_valid.
        S_DIV: if (cnt_done) begin
          result_q    <= clamp_unit(div_q);
          zero_norm_q <= 1'b0;
          nan_flag_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  fp_mult #(.LAT(MUL_LAT)) u_mult (
    .clk    (clk),
    .areset (reset),
    .a      (mult_a),
    .b      (mult_b),
    .q      (mult_q)
  );

  fp_sqrt #(.LAT(SQRT_LAT)) u_sqrt (
    .clk    (clk),
    .areset (reset),
    .a      (sqrt_a),
    .q      (sqrt_q)
  );

  fp_div #(.LAT(DIV_LAT)) u_div (
    .clk    (clk),
    .areset (reset),
    .a      (div_a),
    .b      (div_b),
    .q      (div_q)
  );

  assign bus.ready        = ready;
  assign bus.result_valid = result_valid;
  assign bus.result       = result_q;
  assign bus.zero_norm    = zero_norm_q;
  assign bus.nan_flag     = nan_flag_q;

endmodule

// File: tb/tb_cosine_similarity_finalize.sv
// Scoreboard bench for cosine_similarity_finalize: expected results and their
// due cycles are queued at start and checked when result_valid pulses.
module tb_cosine_similarity_finalize;

  localparam int LAT_NORM = 22;
  localparam int LAT_SPEC = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic chk_ready = 1'b0;

  typedef struct {
    logic [31:0] res;
    logic        zn;
    logic        nf;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  cosine_similarity_finalize_if #(.HV_DATA_WIDTH(32)) bus ();

  cosine_similarity_finalize #(
    .HV_DATA_WIDTH (32),
    .MUL_LAT       (3),
    .SQRT_LAT      (8),
    .DIV_LAT       (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_tests++;
    if (obs !== expd) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, expd, cyc);
    end
  endtask

  // Monitor: every result_valid must match the single outstanding request.
  always @(negedge clk) begin
    if (chk_ready) begin
      check("ready_after_valid", 32'(bus.ready), 32'd1);
      chk_ready = 1'b0;
    end
    if (bus.result_valid === 1'b1) begin
      check("outstanding", sb.size(), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("result", bus.result, e.res);
        check("zero_norm", 32'(bus.zero_norm), 32'(e.zn));
        check("nan_flag", 32'(bus.nan_flag), 32'(e.nf));
        check("latency", cyc, e.due);
      end
      check("ready_low_with_valid", 32'(bus.ready), 32'd0);
      chk_ready = 1'b1;
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic send(input logic [31:0] aa, input logic [31:0] bb, input logic [31:0] ab,
                      input logic [31:0] res, input logic zn, input logic nf,
                      input int lat, output int t0);
    int guard;
    guard = 0;
    while (bus.ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("ready_wait", 32'(bus.ready), 32'd1);
    bus.AA_in = aa;
    bus.BB_in = bb;
    bus.AB_in = ab;
    bus.start = 1'b1;
    t0 = cyc;
    sb.push_back('{res, zn, nf, cyc + lat});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("drain", sb.size(), 32'd0);
  endtask

  task automatic pulse_start_at(input int c);
    wait_cyc(c);
    bus.AA_in = 32'h0000_0000;
    bus.BB_in = 32'h0000_0000;
    bus.AB_in = 32'h0000_0000;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    int t0;
    bus.start = 1'b0;
    bus.AA_in = '0;
    bus.BB_in = '0;
    bus.AB_in = '0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_result", bus.result, 32'h0000_0000);
    check("rst_valid", 32'(bus.result_valid), 32'd0);
    check("rst_zero_norm", 32'(bus.zero_norm), 32'd0);
    check("rst_nan_flag", 32'(bus.nan_flag), 32'd0);

    // Normal path, then back-to-back requests accepted right after ready.
    send(32'h4080_0000, 32'h4110_0000, 32'h40C0_0000, 32'h3F80_0000, 1'b0, 1'b0, LAT_NORM, t0);
    send(32'h4080_0000, 32'h4110_0000, 32'hC040_0000, 32'hBF00_0000, 1'b0, 1'b0, LAT_NORM, t0);
    send(32'h0000_0000, 32'h4110_0000, 32'h40C0_0000, 32'h0000_0000, 1'b1, 1'b0, LAT_SPEC, t0);
    send(32'h8000_0000, 32'h4110_0000, 32'h40C0_0000, 32'h0000_0000, 1'b1, 1'b0, LAT_SPEC, t0);
    send(32'h4080_0000, 32'h7F80_0000, 32'h40C0_0000, 32'h7FC0_0000, 1'b0, 1'b1, LAT_SPEC, t0);

    // Flags and result hold through the next computation, then clear.
    send(32'h4080_0000, 32'h4110_0000, 32'h40C0_0000, 32'h3F80_0000, 1'b0, 1'b0, LAT_NORM, t0);
    wait_cyc(t0 + 5);
    check("nan_flag_held", 32'(bus.nan_flag), 32'd1);
    check("result_held", bus.result, 32'h7FC0_0000);
    drain();

    // Clamp just above |1.0|.
    send(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0001, 32'h3F80_0000, 1'b0, 1'b0, LAT_NORM, t0);
    send(32'h3F80_0000, 32'h3F80_0000, 32'hBF80_0001, 32'hBF80_0000, 1'b0, 1'b0, LAT_NORM, t0);
    drain();

    // Starts while busy are ignored; the monitor rejects any extra result.
    send(32'h4080_0000, 32'h4110_0000, 32'h40C0_0000, 32'h3F80_0000, 1'b0, 1'b0, LAT_NORM, t0);
    pulse_start_at(t0 + 5);
    pulse_start_at(t0 + 21);
    drain();
    repeat (30) @(negedge clk);

    // Reset mid-operation aborts the request without a result.
    send(32'h4080_0000, 32'h4110_0000, 32'hC040_0000, 32'hBF00_0000, 1'b0, 1'b0, LAT_NORM, t0);
    wait_cyc(t0 + 10);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_result", bus.result, 32'h0000_0000);
    check("abort_zero_norm", 32'(bus.zero_norm), 32'd0);
    check("abort_nan_flag", 32'(bus.nan_flag), 32'd0);
    repeat (30) @(negedge clk);
    send(32'h4080_0000, 32'h4110_0000, 32'h40C0_0000, 32'h3F80_0000, 1'b0, 1'b0, LAT_NORM, t0);
    drain();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cosine_similarity_finalize.md
Name: cosine_similarity_finalize

Overview:
Downstream stage of the cosine-similarity accumulator. It consumes the three FP32 sums sum(A·A), sum(B·B) and sum(A·B) once the accumulator reports done, and computes cos = AB / sqrt(AA·BB). It time-multiplexes one fp_mult, one fp_sqrt and one fp_div IP through a latency-counting FSM. It emits one registered FP32 result per request, with a one-cycle valid pulse.

Parameters:
HV_DATA_WIDTH, 32, operand/result width (IEEE-754 single precision; only 32 is supported)
MUL_LAT, 3, fp_mult latency in cycles
SQRT_LAT, 8, fp_sqrt latency in cycles
DIV_LAT, 10, fp_div latency in cycles

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset; also drives IP areset
start  in  1  request pulse; sampled only while ready=1
AA_in  in  HV_DATA_WIDTH  sum(A·A), FP32
BB_in  in  HV_DATA_WIDTH  sum(B·B), FP32
AB_in  in  HV_DATA_WIDTH  sum(A·B), FP32
ready  out  1  high in S_IDLE only
result  out  HV_DATA_WIDTH  cosine similarity, FP32, held until next result
result_valid  out  1  one-cycle pulse when result updates
zero_norm  out  1  AA or BB was ±0; valid with result_valid, held
nan_flag  out  1  any input was NaN/Inf; valid with result_valid, held

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- Reset values:
  - state = S_IDLE
  - ready = 1 from the first cycle after reset deasserts
  - result = 0x00000000
  - result_valid, zero_norm, nan_flag = 0
  - operand latches = 0
- Reset asserted mid-operation aborts the computation. No result_valid is produced for the aborted request.
- Handshake:
  - start && ready at cycle T0 latches AA_in, BB_in and AB_in, and clears ready.
  - start while ready=0 is ignored and not queued.
- Classification at T0 (exponent 0xFF means NaN/Inf; bits[30:0]==0 means zero):
  - Any input NaN/Inf: result=0x7FC00000, nan_flag=1, zero_norm=0, go to S_OUT.
  - Otherwise AA or BB zero: result=0x00000000, zero_norm=1, nan_flag=0, go to S_OUT.
  - Otherwise: go to S_MUL.
- Special cases: result_valid is high in cycle T0+1, and ready returns high at T0+2.
- FSM states (package enum): S_IDLE, S_MUL, S_SQRT, S_DIV, S_OUT.
  - S_MUL: drive fp_mult a=AA, b=BB, held stable for MUL_LAT cycles. Down-counter loaded with LAT-1 on state entry. When the counter reaches 0, register P = q and go to S_SQRT.
  - S_SQRT: fp_sqrt a=P, held for SQRT_LAT cycles. Register S and go to S_DIV.
  - S_DIV: fp_div a=AB, b=S, held for DIV_LAT cycles. Register Q and go to S_OUT.
  - S_OUT:
    - Clamp: if Q[30:0] > 0x3F800000, result = {Q[31], 0x3F800000[30:0]}; otherwise result = Q.
    - result_valid = 1 for this one cycle; zero_norm and nan_flag are cleared.
    - Go to S_IDLE; ready goes high the next cycle.
- Normal-path latency: result_valid is high at cycle T0+1+MUL_LAT+SQRT_LAT+DIV_LAT (T0+22 with defaults). ready is high at that cycle +1. Back-to-back start is accepted at that cycle +1.
- IP inputs are driven to 0 outside their own state. The counter is wide enough for max(MUL_LAT, SQRT_LAT, DIV_LAT).
- Negative AA/BB (not expected from the accumulator) are not special-cased; the sqrt IP's NaN propagates to the result.

Decomposition:
- cosine_similarity_pkg:
  - state enum cosine_finalize_state_t
  - FP32 constants: FP32_ONE=0x3F800000, FP32_QNAN=0x7FC00000, FP32_ZERO
  - function is_nan_inf(), function is_zero()
- No sub-module beyond the three FP IPs (fp_mult, fp_sqrt, fp_div). Classification is small enough to stay as package functions.

Test Plan:
- AA=0x40800000 (4.0), BB=0x41100000 (9.0), AB=0x40C00000 (6.0), start at T0 -> result=0x3F800000, result_valid exactly at T0+22, ready high at T0+23, flags 0.
- AA=4.0, BB=9.0, AB=0xC0400000 (-3.0) -> result=0xBF000000 (-0.5) at T0+22.
- AA=0x00000000, BB=9.0, AB=6.0 -> result=0x00000000, zero_norm=1 at T0+1. Repeat with AA=0x80000000 -> same response.
- BB=0x7F800000 (Inf) -> result=0x7FC00000, nan_flag=1 at T0+1. Next normal request -> nan_flag cleared.
- AA=BB=0x3F800000, AB=0x3F800001 -> clamped result=0x3F800000. AB=0xBF800001 -> 0xBF800000.
- start pulses at T0+5 and T0+21 are ignored, giving exactly one result_valid. Reset at T0+10 -> no result_valid, ready=1 after reset, result=0, and a new request then completes normally.
